// File: rtl/sym_err_rate_counter.sv
`default_nettype none
// ============================================================================
// sym_err_rate_counter : per-LFSR-window I/Q symbol error counter with lock flag
// Optional SER_BURST_EN adds max_burst output.  Rev 1.0
// ============================================================================
module sym_err_rate_counter #(
    parameter int CNT_WID      = 22,
    parameter int LOCK_THR     = 16,
    parameter int SKIP_WINDOWS = 1
) (
    input  logic               sys_clk,
    input  logic               reset,
    input  logic               sym_clk_en,
    input  logic               cycle,
    input  logic               sym_err_i,
    input  logic               sym_err_q,
    input  logic               resync,
    output logic [CNT_WID-1:0] err_cnt_i,
    output logic [CNT_WID-1:0] err_cnt_q,
    output logic [CNT_WID-1:0] err_cnt_any,
    output logic [CNT_WID-1:0] sym_cnt,
`ifdef SER_BURST_EN
    output logic [CNT_WID-1:0] max_burst,
`endif
    output logic               result_valid,
    output logic               sync_ok,
    output logic [1:0]         state_o
);

    localparam int                 c_SKW       = (SKIP_WINDOWS > 1) ? $clog2(SKIP_WINDOWS + 1) : 1;
    localparam logic [c_SKW-1:0]   c_SKIP_INIT = c_SKW'(SKIP_WINDOWS);
    localparam logic [CNT_WID-1:0] c_MAX       = '1;
    localparam int                 c_CMPW      = CNT_WID + 33;

    typedef enum logic [1:0] {
        ST_WAIT_SYNC = 2'd0,
        ST_SKIP      = 2'd1,
        ST_COUNT     = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_SKW-1:0]   r_skip;
    logic [CNT_WID-1:0] r_sym_run, r_i_run, r_q_run, r_any_run;
    logic [CNT_WID-1:0] r_err_cnt_i, r_err_cnt_q, r_err_cnt_any, r_sym_cnt;
    logic               r_valid, r_sync_ok;
    logic               w_qb, w_err_any, w_counting, w_publish, w_lock;

    function automatic logic [CNT_WID-1:0] f_inc(input logic [CNT_WID-1:0] v, input logic en);
        return (en && (v != c_MAX)) ? v + 1'b1 : v;
    endfunction

    assign w_qb       = sym_clk_en & cycle;
    assign w_err_any  = sym_err_i | sym_err_q;
    assign w_counting = (r_state != ST_WAIT_SYNC);
    assign w_publish  = w_qb & (r_state == ST_COUNT) & ~resync;
    // Widened compare so a LOCK_THR beyond the counter range never truncates.
    assign w_lock     = c_CMPW'(r_any_run) <= c_CMPW'(LOCK_THR);

    always_comb begin
        w_state_nxt = r_state;
        if (resync) begin
            w_state_nxt = ST_WAIT_SYNC;
        end else if (w_qb) begin
            case (r_state)
                ST_WAIT_SYNC: w_state_nxt = (SKIP_WINDOWS > 0) ? ST_SKIP : ST_COUNT;
                ST_SKIP:      w_state_nxt = (r_skip <= c_SKW'(1)) ? ST_COUNT : ST_SKIP;
                ST_COUNT:     w_state_nxt = ST_COUNT;
                default:      w_state_nxt = ST_WAIT_SYNC;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_WAIT_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The boundary symbol opens the next window, so a QB reloads rather than clears.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_skip    <= c_SKIP_INIT;
            r_sym_run <= '0;
            r_i_run   <= '0;
            r_q_run   <= '0;
            r_any_run <= '0;
        end else if (resync) begin
            r_skip    <= c_SKIP_INIT;
            r_sym_run <= '0;
            r_i_run   <= '0;
            r_q_run   <= '0;
            r_any_run <= '0;
        end else if (w_qb) begin
            if (r_state == ST_SKIP && r_skip != '0) begin
                r_skip <= r_skip - 1'b1;
            end
            r_sym_run <= CNT_WID'(1);
            r_i_run   <= CNT_WID'(sym_err_i);
            r_q_run   <= CNT_WID'(sym_err_q);
            r_any_run <= CNT_WID'(w_err_any);
        end else if (sym_clk_en && w_counting) begin
            r_sym_run <= f_inc(r_sym_run, 1'b1);
            r_i_run   <= f_inc(r_i_run, sym_err_i);
            r_q_run   <= f_inc(r_q_run, sym_err_q);
            r_any_run <= f_inc(r_any_run, w_err_any);
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_valid       <= 1'b0;
            r_sync_ok     <= 1'b0;
            r_err_cnt_i   <= '0;
            r_err_cnt_q   <= '0;
            r_err_cnt_any <= '0;
            r_sym_cnt     <= '0;
        end else begin
            r_valid <= w_publish;
            if (resync) begin
                r_sync_ok <= 1'b0;
            end else if (w_publish) begin
                r_sync_ok     <= w_lock;
                r_err_cnt_i   <= r_i_run;
                r_err_cnt_q   <= r_q_run;
                r_err_cnt_any <= r_any_run;
                r_sym_cnt     <= r_sym_run;
            end
        end
    end

`ifdef SER_BURST_EN
    logic [CNT_WID-1:0] r_cur_burst, r_win_burst, r_max_burst;
    logic [CNT_WID-1:0] w_cur_inc, w_win_max;

    assign w_cur_inc = f_inc(r_cur_burst, 1'b1);
    assign w_win_max = (w_cur_inc > r_win_burst) ? w_cur_inc : r_win_burst;

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_cur_burst <= '0;
            r_win_burst <= '0;
            r_max_burst <= '0;
        end else if (resync) begin
            r_cur_burst <= '0;
            r_win_burst <= '0;
        end else if (w_qb) begin
            if (w_publish) begin
                r_max_burst <= r_win_burst;
            end
            r_cur_burst <= CNT_WID'(w_err_any);
            r_win_burst <= CNT_WID'(w_err_any);
        end else if (sym_clk_en && w_counting) begin
            if (w_err_any) begin
                r_cur_burst <= w_cur_inc;
                r_win_burst <= w_win_max;
            end else begin
                r_cur_burst <= '0;
            end
        end
    end

    assign max_burst = r_max_burst;
`endif

    assign err_cnt_i    = r_err_cnt_i;
    assign err_cnt_q    = r_err_cnt_q;
    assign err_cnt_any  = r_err_cnt_any;
    assign sym_cnt      = r_sym_cnt;
    assign result_valid = r_valid;
    assign sync_ok      = r_sync_ok;
    assign state_o      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_sym_err_rate_counter.sv
`default_nettype none
// ============================================================================
// tb_sym_err_rate_counter : directed bench, 22-bit and 4-bit (saturating) DUTs
// Rev 1.0
// ============================================================================
module tb_sym_err_rate_counter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0, cyc = 1'b0, ei = 1'b0, eq = 1'b0, rsy = 1'b0;

    logic [21:0] a_i, a_q, a_any, a_sym;
    logic [3:0]  b_i, b_q, b_any, b_sym;
    logic        a_valid, a_sync, b_valid, b_sync;
    logic [1:0]  a_state, b_state;
`ifdef SER_BURST_EN
    logic [21:0] a_burst;
    logic [3:0]  b_burst;
`endif

    int n_vec = 0;
    int n_err = 0;

    // expected published values (22-bit view); the 4-bit DUT expects them saturated at 15
    int e_valid, e_state, e_i, e_q, e_any, e_sym, e_sync, e_burst, e_sync_b;

    always #5 clk = ~clk;

    sym_err_rate_counter #(.CNT_WID(22), .LOCK_THR(16), .SKIP_WINDOWS(1)) u_dut_a (
        .sys_clk(clk), .reset(rst), .sym_clk_en(en), .cycle(cyc),
        .sym_err_i(ei), .sym_err_q(eq), .resync(rsy),
        .err_cnt_i(a_i), .err_cnt_q(a_q), .err_cnt_any(a_any), .sym_cnt(a_sym),
`ifdef SER_BURST_EN
        .max_burst(a_burst),
`endif
        .result_valid(a_valid), .sync_ok(a_sync), .state_o(a_state)
    );

    sym_err_rate_counter #(.CNT_WID(4), .LOCK_THR(16), .SKIP_WINDOWS(1)) u_dut_b (
        .sys_clk(clk), .reset(rst), .sym_clk_en(en), .cycle(cyc),
        .sym_err_i(ei), .sym_err_q(eq), .resync(rsy),
        .err_cnt_i(b_i), .err_cnt_q(b_q), .err_cnt_any(b_any), .sym_cnt(b_sym),
`ifdef SER_BURST_EN
        .max_burst(b_burst),
`endif
        .result_valid(b_valid), .sync_ok(b_sync), .state_o(b_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat4(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic check_pub();
        chk("a_valid", 32'(a_valid), e_valid);
        chk("a_state", 32'(a_state), e_state);
        chk("a_err_i", 32'(a_i), e_i);
        chk("a_err_q", 32'(a_q), e_q);
        chk("a_err_any", 32'(a_any), e_any);
        chk("a_sym_cnt", 32'(a_sym), e_sym);
        chk("a_sync_ok", 32'(a_sync), e_sync);
        chk("b_valid", 32'(b_valid), e_valid);
        chk("b_state", 32'(b_state), e_state);
        chk("b_err_i", 32'(b_i), sat4(e_i));
        chk("b_err_q", 32'(b_q), sat4(e_q));
        chk("b_err_any", 32'(b_any), sat4(e_any));
        chk("b_sym_cnt", 32'(b_sym), sat4(e_sym));
        chk("b_sync_ok", 32'(b_sync), e_sync_b);
`ifdef SER_BURST_EN
        chk("a_max_burst", 32'(a_burst), e_burst);
        chk("b_max_burst", 32'(b_burst), sat4(e_burst));
`endif
    endtask

    // one symbol = one qualified clock followed by one idle clock
    task automatic sym(input logic si, input logic sq, input logic c, input logic rs);
        @(negedge clk);
        en = 1'b1; ei = si; eq = sq; cyc = c; rsy = rs;
        @(negedge clk);
        en = 1'b0; ei = 1'b0; eq = 1'b0; cyc = 1'b0; rsy = 1'b0;
    endtask

    // symbol 0 carries the boundary; published results are checked right after it
    task automatic run_window(input int n, input logic [31:0] im, input logic [31:0] qm, input logic rs);
        sym(im[0], qm[0], 1'b1, rs);
        check_pub();
        for (int k = 1; k < n; k++) begin
            sym(im[k], qm[k], 1'b0, 1'b0);
        end
    endtask

    task automatic set_exp(input int v, input int st, input int i, input int q, input int an,
                           input int s, input int sy, input int bu, input int syb);
        e_valid = v; e_state = st; e_i = i; e_q = q; e_any = an;
        e_sym = s; e_sync = sy; e_burst = bu; e_sync_b = syb;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        set_exp(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_pub();

        e_state = 1;                                   // first QB: into SKIP
        run_window(10, 32'h0, 32'h0, 1'b0);
        e_state = 2;                                   // skip window done: COUNT
        run_window(10, 32'h0, 32'h0, 1'b0);
        set_exp(1, 2, 0, 0, 0, 10, 1, 0, 1);           // clean window published
        run_window(10, 32'h0000_002A, 32'h0000_00A0, 1'b0);
        set_exp(1, 2, 3, 2, 4, 10, 1, 1, 1);           // I on 1,3,5  Q on 5,7
        run_window(25, 32'h000F_FFFF, 32'h0, 1'b0);
        set_exp(1, 2, 20, 0, 20, 25, 0, 20, 1);        // 20 errors: unlock, 4-bit saturates
        run_window(10, 32'h0000_0001, 32'h0, 1'b0);
        set_exp(1, 2, 1, 0, 1, 10, 1, 1, 1);           // boundary error counted in its own window
        run_window(10, 32'h0, 32'h0, 1'b0);

        set_exp(0, 0, 1, 0, 1, 10, 0, 1, 0);           // resync with QB: nothing published
        run_window(10, 32'h0, 32'h0, 1'b1);
        e_state = 1;
        run_window(10, 32'h0, 32'h0, 1'b0);
        e_state = 2;
        run_window(10, 32'h0000_01FC, 32'h0, 1'b0);
        set_exp(1, 2, 7, 0, 7, 10, 1, 7, 1);           // burst on symbols 2..8
        run_window(4, 32'h0000_0005, 32'h0, 1'b0);

        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        set_exp(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_pub();
        @(negedge clk);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
